// File: rtl/axi_datamover_read_split_if.sv
// Bundles the client request/data/response signals and the DataMover MM2S command/data/status signals.
// master is the splitter's view of the bundle; slave is the view from the clients and the DataMover.
interface axi_datamover_read_split_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH = 24,
  parameter int CMD_WIDTH  = ADDR_WIDTH + 40
);
  logic                    ddr_rreq_ready;
  logic                    ddr_rreq_valid;
  logic [ADDR_WIDTH-1:0]   ddr_rreq_addr;
  logic [SIZE_WIDTH-1:0]   ddr_rreq_size;
  logic                    ddr_rdata_ready;
  logic                    ddr_rdata_valid;
  logic                    ddr_rdata_last;
  logic [DATA_WIDTH-1:0]   ddr_rdata;
  logic                    ddr_rresp_valid;
  logic [1:0]              ddr_rresp;
  logic [CMD_WIDTH-1:0]    mm2s_cmd_tdata;
  logic                    mm2s_cmd_tvalid;
  logic                    mm2s_cmd_tready;
  logic [DATA_WIDTH-1:0]   mm2s_tdata;
  logic [DATA_WIDTH/8-1:0] mm2s_tkeep;
  logic                    mm2s_tlast;
  logic                    mm2s_tvalid;
  logic                    mm2s_tready;
  logic [7:0]              mm2s_sts_tdata;
  logic                    mm2s_sts_tvalid;
  logic                    mm2s_sts_tready;

  modport master (
    output ddr_rreq_ready,
    input  ddr_rreq_valid, ddr_rreq_addr, ddr_rreq_size,
    input  ddr_rdata_ready,
    output ddr_rdata_valid, ddr_rdata_last, ddr_rdata,
    output ddr_rresp_valid, ddr_rresp,
    output mm2s_cmd_tdata, mm2s_cmd_tvalid,
    input  mm2s_cmd_tready,
    input  mm2s_tdata, mm2s_tkeep, mm2s_tlast, mm2s_tvalid,
    output mm2s_tready,
    input  mm2s_sts_tdata, mm2s_sts_tvalid,
    output mm2s_sts_tready
  );

  modport slave (
    input  ddr_rreq_ready,
    output ddr_rreq_valid, ddr_rreq_addr, ddr_rreq_size,
    output ddr_rdata_ready,
    input  ddr_rdata_valid, ddr_rdata_last, ddr_rdata,
    input  ddr_rresp_valid, ddr_rresp,
    input  mm2s_cmd_tdata, mm2s_cmd_tvalid,
    output mm2s_cmd_tready,
    output mm2s_tdata, mm2s_tkeep, mm2s_tlast, mm2s_tvalid,
    input  mm2s_tready,
    output mm2s_sts_tdata, mm2s_sts_tvalid,
    input  mm2s_sts_tready
  );
endinterface

// File: rtl/axi_datamover_read_split.sv
// Splits DDR read requests into MAX_BTT-aligned DataMover MM2S commands, folds statuses into one response
// and regenerates a single end-of-request last flag. Optional counters: define AXI_DM_RD_STATS_EN.
module axi_datamover_read_split #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int SIZE_WIDTH      = 24,
  parameter int MAX_BTT         = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMD_WIDTH       = ADDR_WIDTH + 40
) (
  input  logic                       clk,
  input  logic                       rst,
  axi_datamover_read_split_if.master bus
`ifdef AXI_DM_RD_STATS_EN
  ,
  output logic [31:0]                stat_req_cnt,
  output logic [31:0]                stat_cmd_cnt,
  output logic [31:0]                stat_err_cnt
`endif
);
  localparam int LOG2 = $clog2(MAX_BTT);
  localparam int CW   = SIZE_WIDTH + 1;
  localparam int TW   = SIZE_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [SIZE_WIDTH-1:0]   remaining_q, remaining_d;
  logic [CW-1:0]           total_chunks_q, total_chunks_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic [3:0]              tag_q, tag_d;
  logic [3:0]              exp_tag_q, exp_tag_d;
  logic [3:0]              outstanding_q, outstanding_d;
  logic                    err_q, err_d;
  logic                    tag_err_q, tag_err_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic [CMD_WIDTH-1:0]    cmd_dat_q, cmd_dat_d;
  logic                    rresp_vld_q, rresp_vld_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    req_hs, cmd_hs, sts_hs, last_hs, rdata_last, final_chunk;
  logic [CW-1:0]           space, chunk_len;
  logic [TW-1:0]           chunk_sum;
  logic [DATA_WIDTH/8-1:0] unused_keep;

  // Bytes left before the next MAX_BTT boundary bound every command.
  assign space       = CW'(MAX_BTT) - CW'(cur_addr_q[LOG2-1:0]);
  assign chunk_len   = ({1'b0, remaining_q} < space) ? {1'b0, remaining_q} : space;
  assign final_chunk = ({1'b0, remaining_q} == chunk_len);
  assign chunk_sum   = TW'(bus.ddr_rreq_addr[LOG2-1:0]) + TW'(bus.ddr_rreq_size) + TW'(MAX_BTT - 1);

  assign req_hs     = bus.ddr_rreq_valid && (state_q == IDLE);
  assign cmd_hs     = cmd_vld_q && bus.mm2s_cmd_tready;
  assign sts_hs     = bus.mm2s_sts_tvalid;
  assign last_hs    = bus.mm2s_tvalid && bus.ddr_rdata_ready && bus.mm2s_tlast;
  assign rdata_last = bus.mm2s_tlast && (beat_cnt_q == total_chunks_q - CW'(1));

  assign bus.ddr_rreq_ready  = (state_q == IDLE);
  assign bus.ddr_rdata       = bus.mm2s_tdata;
  assign bus.ddr_rdata_valid = bus.mm2s_tvalid;
  assign bus.ddr_rdata_last  = rdata_last;
  assign bus.mm2s_tready     = bus.ddr_rdata_ready;
  assign bus.ddr_rresp_valid = rresp_vld_q;
  assign bus.ddr_rresp       = rresp_q;
  assign bus.mm2s_cmd_tdata  = cmd_dat_q;
  assign bus.mm2s_cmd_tvalid = cmd_vld_q;
  assign bus.mm2s_sts_tready = 1'b1;
  assign unused_keep         = bus.mm2s_tkeep;

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    remaining_d    = remaining_q;
    total_chunks_d = total_chunks_q;
    beat_cnt_d     = beat_cnt_q;
    tag_d          = tag_q;
    exp_tag_d      = exp_tag_q;
    outstanding_d  = outstanding_q;
    err_d          = err_q;
    tag_err_d      = tag_err_q;
    cmd_vld_d      = cmd_vld_q;
    cmd_dat_d      = cmd_dat_q;
    rresp_vld_d    = 1'b0;
    rresp_d        = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          if (bus.ddr_rreq_size == '0) begin
            rresp_vld_d = 1'b1;
            rresp_d     = 2'b10;
          end else begin
            cur_addr_d     = bus.ddr_rreq_addr;
            remaining_d    = bus.ddr_rreq_size;
            total_chunks_d = CW'(chunk_sum >> LOG2);
            err_d          = 1'b0;
            tag_err_d      = 1'b0;
            state_d        = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!cmd_vld_q && (outstanding_q < 4'(MAX_OUTSTANDING))) begin
          cmd_vld_d = 1'b1;
          cmd_dat_d = {4'h0, tag_q, cur_addr_q, 1'b0, final_chunk, 6'h0, 1'b1, 23'(chunk_len)};
        end
        if (cmd_hs) begin
          cmd_vld_d   = 1'b0;
          cur_addr_d  = cur_addr_q + ADDR_WIDTH'(chunk_len);
          remaining_d = remaining_q - SIZE_WIDTH'(chunk_len);
          tag_d       = tag_q + 4'd1;
          if (final_chunk) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_q == 4'd0) begin
          rresp_vld_d = 1'b1;
          rresp_d     = tag_err_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sts_hs) begin
      exp_tag_d = exp_tag_q + 4'd1;
      if (!bus.mm2s_sts_tdata[7] || (bus.mm2s_sts_tdata[6:4] != 3'b000)) err_d = 1'b1;
      if (bus.mm2s_sts_tdata[3:0] != exp_tag_q) tag_err_d = 1'b1;
    end

    // A command and a status in the same cycle cancel out.
    if (cmd_hs && !sts_hs)                              outstanding_d = outstanding_q + 4'd1;
    else if (!cmd_hs && sts_hs && outstanding_q != '0)  outstanding_d = outstanding_q - 4'd1;

    if (last_hs) beat_cnt_d = rdata_last ? '0 : beat_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      remaining_q    <= '0;
      total_chunks_q <= '0;
      beat_cnt_q     <= '0;
      tag_q          <= '0;
      exp_tag_q      <= '0;
      outstanding_q  <= '0;
      err_q          <= 1'b0;
      tag_err_q      <= 1'b0;
      cmd_vld_q      <= 1'b0;
      cmd_dat_q      <= '0;
      rresp_vld_q    <= 1'b0;
      rresp_q        <= 2'b00;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      remaining_q    <= remaining_d;
      total_chunks_q <= total_chunks_d;
      beat_cnt_q     <= beat_cnt_d;
      tag_q          <= tag_d;
      exp_tag_q      <= exp_tag_d;
      outstanding_q  <= outstanding_d;
      err_q          <= err_d;
      tag_err_q      <= tag_err_d;
      cmd_vld_q      <= cmd_vld_d;
      cmd_dat_q      <= cmd_dat_d;
      rresp_vld_q    <= rresp_vld_d;
      rresp_q        <= rresp_d;
    end
  end

`ifdef AXI_DM_RD_STATS_EN
  logic [31:0] stat_req_q, stat_cmd_q, stat_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_req_q <= '0;
      stat_cmd_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (req_hs) stat_req_q <= stat_req_q + 32'd1;
      if (cmd_hs) stat_cmd_q <= stat_cmd_q + 32'd1;
      if (rresp_vld_q && (rresp_q != 2'b00)) stat_err_q <= stat_err_q + 32'd1;
    end
  end

  assign stat_req_cnt = stat_req_q;
  assign stat_cmd_cnt = stat_cmd_q;
  assign stat_err_cnt = stat_err_q;
`endif
endmodule

// File: tb/tb_axi_datamover_read_split.sv
// Scoreboard bench: stimulus pushes expected commands, data-last flags and responses; monitors pop and compare.
// A small DataMover stand-in returns data beats and statuses for every accepted command.
module tb_axi_datamover_read_split;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 24;
  localparam int CW = AW + 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_datamover_read_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CMD_WIDTH(CW)) bus ();

`ifdef AXI_DM_RD_STATS_EN
  logic [31:0] stat_req_cnt, stat_cmd_cnt, stat_err_cnt;
`endif

  axi_datamover_read_split #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
    .MAX_BTT(4096), .MAX_OUTSTANDING(4), .CMD_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef AXI_DM_RD_STATS_EN
    ,
    .stat_req_cnt (stat_req_cnt),
    .stat_cmd_cnt (stat_cmd_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;
  int sts_allow = 1000000;
  int sts_seq = 0;
  int err_at = -1;

  logic [CW-1:0] exp_cmd[$];
  logic [1:0]    exp_resp[$];
  bit            exp_last[$];
  int            dm_btt[$];
  logic [3:0]    dm_tag[$];
  logic [3:0]    sts_pend[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                           input logic eof, input logic [22:0] btt);
    return {4'h0, tag, addr, 1'b0, eof, 6'h0, 1'b1, btt};
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    return {32'hD0D0CAFE, 32'(i)};
  endfunction

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) exp_last.push_back(i == n - 1);
  endtask

  // Command monitor; also hands each accepted command to the DataMover stand-in.
  initial forever begin
    @(negedge clk); #2;
    if (!rst && bus.mm2s_cmd_tvalid && bus.mm2s_cmd_tready) begin
      cmd_cnt++;
      dm_btt.push_back(int'(bus.mm2s_cmd_tdata[22:0]));
      dm_tag.push_back(bus.mm2s_cmd_tdata[CW-5 -: 4]);
      if (exp_cmd.size() == 0) begin
        tests++; fails++;
        $display("FAIL cmd_unexpected: got %0h, expected no command", bus.mm2s_cmd_tdata);
      end else check("cmd_tdata", 128'(bus.mm2s_cmd_tdata), 128'(exp_cmd.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk); #2;
    if (bus.ddr_rresp_valid) begin
      if (exp_resp.size() == 0) begin
        tests++; fails++;
        $display("FAIL rresp_unexpected: got %0h, expected no response", bus.ddr_rresp);
      end else check("rresp", 128'(bus.ddr_rresp), 128'(exp_resp.pop_front()));
    end
  end

  initial begin
    int mon_idx;
    mon_idx = 0;
    forever begin
      @(negedge clk); #2;
      if (bus.ddr_rdata_valid && bus.ddr_rdata_ready) begin
        check("rdata", 128'(bus.ddr_rdata), 128'(pat(mon_idx)));
        check("mm2s_tready", 128'(bus.mm2s_tready), 128'(1));
        mon_idx++;
        if (exp_last.size() == 0) begin
          tests++; fails++;
          $display("FAIL rdata_unexpected: got beat %0d, expected no data", mon_idx);
        end else check("rdata_last", 128'(bus.ddr_rdata_last), 128'(exp_last.pop_front()));
      end
    end
  end

  // DataMover data side: btt/8 beats per command, tlast on each command's final beat.
  initial begin
    int left, idx;
    logic [3:0] tag;
    left = 0; idx = 0; tag = 4'h0;
    bus.mm2s_tvalid = 1'b0; bus.mm2s_tlast = 1'b0; bus.mm2s_tdata = '0; bus.mm2s_tkeep = '1;
    forever begin
      @(negedge clk);
      if (left == 0 && dm_btt.size() > 0) begin
        left = dm_btt.pop_front() / (DW / 8);
        tag  = dm_tag.pop_front();
      end
      if (left > 0) begin
        bus.mm2s_tvalid = 1'b1;
        bus.mm2s_tdata  = pat(idx);
        bus.mm2s_tlast  = (left == 1);
        idx++;
        left--;
        if (left == 0) sts_pend.push_back(tag);
      end else begin
        bus.mm2s_tvalid = 1'b0;
        bus.mm2s_tlast  = 1'b0;
      end
    end
  end

  initial begin
    logic [3:0] t;
    bus.mm2s_sts_tvalid = 1'b0; bus.mm2s_sts_tdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (sts_pend.size() > 0 && sts_allow > 0) begin
        t = sts_pend.pop_front();
        bus.mm2s_sts_tvalid = 1'b1;
        bus.mm2s_sts_tdata  = {1'b1, (sts_seq == err_at) ? 3'b100 : 3'b000, t};
        sts_seq++;
        sts_allow--;
      end else bus.mm2s_sts_tvalid = 1'b0;
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [23:0] size);
    int n;
    n = 0;
    @(negedge clk);
    bus.ddr_rreq_valid = 1'b1;
    bus.ddr_rreq_addr  = addr;
    bus.ddr_rreq_size  = size;
    forever begin
      #2;
      if (bus.ddr_rreq_ready) break;
      @(negedge clk);
      n++;
      if (n > 5000) begin
        fails++;
        $display("FAIL req_accept: got ready=0 for %0d cycles, expected ready", n);
        break;
      end
    end
    @(negedge clk);
    bus.ddr_rreq_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || exp_last.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL %s_timeout: got %0d resp/%0d beats/%0d cmds pending, expected 0", name,
               exp_resp.size(), exp_last.size(), exp_cmd.size());
      exp_resp.delete(); exp_last.delete(); exp_cmd.delete();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    bus.ddr_rreq_valid = 1'b0; bus.ddr_rreq_addr = '0; bus.ddr_rreq_size = '0;
    bus.ddr_rdata_ready = 1'b1; bus.mm2s_cmd_tready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("reset_cmd_tvalid", 128'(bus.mm2s_cmd_tvalid), 128'(0));
    check("reset_rresp_valid", 128'(bus.ddr_rresp_valid), 128'(0));
    check("reset_rreq_ready", 128'(bus.ddr_rreq_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;

    // Single aligned chunk.
    exp_cmd.push_back(mk_cmd(4'd0, 32'h1000, 1'b1, 23'h100));
    push_beats(32); exp_resp.push_back(2'b00);
    send_req(32'h1000, 24'h100);
    wait_idle("single", 500);

    // Crosses a 4 KiB boundary.
    exp_cmd.push_back(mk_cmd(4'd1, 32'h0F00, 1'b0, 23'h100));
    exp_cmd.push_back(mk_cmd(4'd2, 32'h1000, 1'b1, 23'h200));
    push_beats(96); exp_resp.push_back(2'b00);
    send_req(32'h0F00, 24'h300);
    wait_idle("split", 500);

    // Outstanding limit with statuses withheld.
    sts_allow = 0;
    base = cmd_cnt;
    for (int i = 0; i < 5; i++)
      exp_cmd.push_back(mk_cmd(4'(3 + i), 32'(i * 32'h1000), 1'b0 + (i == 4), 23'h1000));
    push_beats(2560); exp_resp.push_back(2'b00);
    send_req(32'h0, 24'h5000);
    repeat (40) @(negedge clk);
    #2;
    check("stall_cmd_count", 128'(cmd_cnt - base), 128'(4));
    check("stall_cmd_tvalid", 128'(bus.mm2s_cmd_tvalid), 128'(0));
    sts_allow = 1;
    n = 0;
    while (cmd_cnt - base < 5 && n < 3000) begin @(negedge clk); n++; end
    #2;
    check("release_cmd_count", 128'(cmd_cnt - base), 128'(5));
    sts_allow = 1000000;
    wait_idle("outstanding", 6000);

    // Error on the second status, then a clean request.
    err_at = 9;
    exp_cmd.push_back(mk_cmd(4'd8, 32'h0F80, 1'b0, 23'h80));
    exp_cmd.push_back(mk_cmd(4'd9, 32'h1000, 1'b1, 23'h80));
    push_beats(32); exp_resp.push_back(2'b10);
    send_req(32'h0F80, 24'h100);
    wait_idle("slverr", 500);
    err_at = -1;
    exp_cmd.push_back(mk_cmd(4'd10, 32'h3000, 1'b1, 23'h40));
    push_beats(8); exp_resp.push_back(2'b00);
    send_req(32'h3000, 24'h40);
    wait_idle("after_err", 500);

    // Zero-length request.
    exp_resp.push_back(2'b10);
    send_req(32'h4000, 24'h0);
    #2;
    check("zero_rresp_valid", 128'(bus.ddr_rresp_valid), 128'(1));
    check("zero_rresp", 128'(bus.ddr_rresp), 128'(2'b10));
    check("zero_no_cmd", 128'(bus.mm2s_cmd_tvalid), 128'(0));
    wait_idle("zero", 100);

    // Command held by backpressure, then abandoned by reset.
    bus.mm2s_cmd_tready = 1'b0;
    base = cmd_cnt;
    send_req(32'h2000, 24'h100);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #2;
      check("hold_cmd_tvalid", 128'(bus.mm2s_cmd_tvalid), 128'(1));
      check("hold_cmd_tdata", 128'(bus.mm2s_cmd_tdata), 128'(mk_cmd(4'd11, 32'h2000, 1'b1, 23'h100)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_cmd_tvalid", 128'(bus.mm2s_cmd_tvalid), 128'(0));
    check("rst_rreq_ready", 128'(bus.ddr_rreq_ready), 128'(1));
    bus.mm2s_cmd_tready = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    check("rst_no_cmd", 128'(cmd_cnt - base), 128'(0));

    // Tag counter restarts after reset.
    exp_cmd.push_back(mk_cmd(4'd0, 32'h1000, 1'b1, 23'h80));
    push_beats(16); exp_resp.push_back(2'b00);
    send_req(32'h1000, 24'h80);
    wait_idle("post_reset", 500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_datamover_read_split.md
Name: axi_datamover_read_split

Overview:
- Successor DDR-read front end for the Xilinx AXI DataMover MM2S channel.
- Accepts arbitrary-length read requests and splits them into boundary-aligned DataMover commands, with tag generation and multiple outstanding commands.
- Aggregates per-command status into a single response and regenerates one end-of-request last flag on the data stream.
- Sits between DDR-read clients and the DataMover MM2S command, status and data ports.

Parameters:
- DATA_WIDTH, 64, MM2S data bus width in bits (multiple of 8).
- ADDR_WIDTH, 32, byte address width.
- SIZE_WIDTH, 24, request byte-count width.
- MAX_BTT, 4096, max bytes per command and split boundary (power of 2, <= 2^22).
- MAX_OUTSTANDING, 4, max commands issued without returned status (1..15).
- CMD_WIDTH, ADDR_WIDTH+40, DataMover command width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ddr_rreq_ready  out  1  request accept
- ddr_rreq_valid  in  1  request valid
- ddr_rreq_addr  in  ADDR_WIDTH  start byte address
- ddr_rreq_size  in  SIZE_WIDTH  byte count
- ddr_rdata_ready  in  1  client data ready
- ddr_rdata_valid  out  1  data valid
- ddr_rdata_last  out  1  last beat of whole request
- ddr_rdata  out  DATA_WIDTH  read data
- ddr_rresp_valid  out  1  one-cycle response pulse
- ddr_rresp  out  2  00 OKAY, 10 SLVERR, 11 tag mismatch
- mm2s_cmd_tdata  out  CMD_WIDTH  command
- mm2s_cmd_tvalid  out  1  command valid
- mm2s_cmd_tready  in  1  command ready
- mm2s_tdata  in  DATA_WIDTH  data
- mm2s_tkeep  in  DATA_WIDTH/8  keep (unused)
- mm2s_tlast  in  1  end of one command
- mm2s_tvalid  in  1  data valid
- mm2s_tready  out  1  data ready
- mm2s_sts_tdata  in  8  status
- mm2s_sts_tvalid  in  1  status valid
- mm2s_sts_tready  out  1  status ready, tied 1

Behaviour:
- Reset is synchronous and active-high. While rst is high, every output register is cleared: cmd_tvalid=0, cmd_tdata=0, rresp_valid=0, rresp=0, FSM=IDLE, counters=0. A reset asserted mid-request abandons the request with no response.
- FSM has three states: IDLE, ISSUE, DRAIN.
  - IDLE: ddr_rreq_ready=1, otherwise 0.
  - On handshake with size!=0, latch addr/size, compute total_chunks = (addr[log2(MAX_BTT)-1:0] + size + MAX_BTT-1) >> log2(MAX_BTT) in SIZE_WIDTH+1 bits, clear the error flags, and go to ISSUE.
  - On handshake with size==0, issue no command; next cycle pulse rresp_valid with rresp=10 and stay in IDLE.
- ISSUE:
  - chunk_len = min(remaining, MAX_BTT - (cur_addr mod MAX_BTT)), so no command crosses a MAX_BTT-aligned boundary.
  - When cmd_tvalid=0 and outstanding<MAX_OUTSTANDING, load cmd_tdata and set cmd_tvalid.
  - Command field order, MSB to LSB: rsv 4'h0, tag, cur_addr, drr 0, eof, dsa 6'h0, type 1, btt zero-extended to 23 bits. eof=1 on the final chunk only.
  - cmd_tvalid and cmd_tdata stay stable until cmd_tready.
  - On the command handshake: cur_addr+=chunk_len, remaining-=chunk_len, tag+=1 (mod 16, not reset per request), outstanding+=1. The final chunk's handshake moves the FSM to DRAIN.
  - A new command may load in the cycle after a handshake, giving at most one command per 2 cycles.
- Status handling:
  - Each status beat decrements outstanding. A status beat and a command handshake in the same cycle leave outstanding unchanged.
  - exp_tag increments per status beat.
  - sts[7]==0 or sts[6:4]!=0 sets sticky err. sts[3:0]!=exp_tag sets sticky tag_err.
- DRAIN: when outstanding==0 and every command has been issued, pulse rresp_valid for 1 cycle with rresp = tag_err ? 11 : err ? 10 : 00, then return to IDLE. The request-to-response latency is therefore fixed by the last status plus one cycle.
- Data path is combinational pass-through: ddr_rdata=mm2s_tdata, ddr_rdata_valid=mm2s_tvalid, mm2s_tready=ddr_rdata_ready.
- A last-beat counter counts mm2s_tlast beats. ddr_rdata_last = mm2s_tlast && (beat count == total_chunks-1). The counter clears at the last handshake.
- Status beats may arrive before the corresponding data finishes; response timing is independent of the data path.

Optional Feature:
- Macro: AXI_DM_RD_STATS_EN.
- When defined, add outputs stat_req_cnt (32 bits, requests accepted), stat_cmd_cnt (32 bits, commands issued) and stat_err_cnt (32 bits, responses with rresp!=00).
- The counters clear on rst and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- addr=0x1000, size=256, tready=1: one command, btt=256, eof=1, tag 0; one status 0x80; 32 beats with last on beat 32; rresp=00.
- addr=0x0F00, size=0x300: two commands, 0x0F00/btt 0x100 then 0x1000/btt 0x200, tags 0 and 1. ddr_rdata_last only on the second tlast.
- size=0x5000 at addr 0 with MAX_OUTSTANDING=4 and status withheld: exactly 4 commands issued, then stall. Release one status -> 5th issues; after all 5 statuses -> rresp=00.
- Two-chunk request with second status 0xC1: rresp=10. Next request rresp=00, confirming the error flag is not sticky across requests.
- size=0: no cmd_tvalid; rresp_valid pulse with rresp=10 one cycle after the handshake.
- cmd_tready low for 10 cycles: cmd_tdata stable; rst pulse mid-ISSUE -> cmd_tvalid=0 next cycle, ddr_rreq_ready=1, no response.
